// File: rtl/video_test_gen_pkg.sv
// Shared types, state encoding and cell helpers for the text-mode test-pattern writer.
package video_test_gen_pkg;

  localparam int unsigned DISP_ADDR_W = 12;
  localparam int unsigned COLOR_W     = 4;

  typedef logic [DISP_ADDR_W-1:0] disp_addr_t;
  typedef logic [COLOR_W-1:0]     color_t;
  typedef logic [1:0]             test_mode_t;

  // One character cell as stored in display memory.
  typedef struct packed {
    color_t     back;
    color_t     fore;
    logic [7:0] ch;
  } disp_data_t;

  typedef enum logic [1:0] {
    TEST_WAIT  = 2'd0,
    TEST_WRITE = 2'd1,
    TEST_NEXT  = 2'd2
  } test_st;

  localparam test_mode_t TEST_MODE_MESSAGE = 2'd0;
  localparam test_mode_t TEST_MODE_FILL    = 2'd1;
  localparam test_mode_t TEST_MODE_CHARSET = 2'd2;

  // Foreground actually emitted: bumped by 5 so text never matches its background.
  function automatic color_t emit_fore(input color_t fore, input color_t back);
    return (fore == back) ? color_t'(fore + color_t'(5)) : fore;
  endfunction

  // Assemble a cell from character and the raw colour registers.
  function automatic disp_data_t make_cell(input logic [7:0] ch, input color_t fore,
                                           input color_t back);
    disp_data_t c;
    c.back = back;
    c.fore = emit_fore(fore, back);
    c.ch   = ch;
    return c;
  endfunction

endpackage

// File: rtl/video_test_gen_if.sv
// Display-memory write port with valid/ready handshake.
interface video_test_gen_if;
  import video_test_gen_pkg::*;

  logic       wr_en_o;
  logic       wr_ready_i;
  disp_addr_t wr_addr_o;
  disp_data_t wr_data_o;

  modport master (output wr_en_o, output wr_addr_o, output wr_data_o, input wr_ready_i);
  modport slave  (input wr_en_o, input wr_addr_o, input wr_data_o, output wr_ready_i);
endinterface

// File: rtl/video_frame_timer.sv
// Counts end-of-frame pulses up to FRAME_DELAY; hit stays high until cleared.
module video_frame_timer #(
  parameter int unsigned FRAME_DELAY = 300
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int unsigned CNT_W = $clog2(FRAME_DELAY + 1);

  logic [CNT_W-1:0] cnt;

  // Saturating frame counter with registered terminal flag.
  always_ff @(posedge clk) begin
    if (!rst_ni || clear) begin
      cnt <= '0;
      hit <= 1'b0;
    end else if (enable && !hit) begin
      cnt <= cnt + CNT_W'(1);
      hit <= (cnt == CNT_W'(FRAME_DELAY - 1));
    end
  end

endmodule

// File: rtl/video_test_gen.sv
// Periodic burst writer of message / fill / charset patterns into text display memory.
module video_test_gen
  import video_test_gen_pkg::*;
#(
  parameter int unsigned TEXT_COLS   = 80,
  parameter int unsigned TEXT_ROWS   = 30,
  parameter int unsigned FRAME_DELAY = 300,
  parameter int unsigned MESSAGE_LEN = 20,
  parameter logic [MESSAGE_LEN*8-1:0] MESSAGE = "Hello Upduino VGA!  "
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  test_mode_t       mode_i,
  input  logic             eof_i,
  video_test_gen_if.master wr,
  output logic             busy_o,
  output logic             burst_done_o
);

  localparam int unsigned SCREEN_CELLS = TEXT_COLS * TEXT_ROWS;
  localparam int unsigned CHARSET_LEN  = (SCREEN_CELLS < 256) ? SCREEN_CELLS : 256;
  localparam int unsigned MAX_LEN      = (SCREEN_CELLS > MESSAGE_LEN) ? SCREEN_CELLS : MESSAGE_LEN;
  localparam int unsigned LEN_W        = $clog2(MAX_LEN + 1);
  localparam disp_addr_t  LAST_ADDR    = disp_addr_t'(SCREEN_CELLS - 1);

  test_st           state;
  test_mode_t       mode_q;
  disp_addr_t       msg_addr;
  color_t           bcolor;
  color_t           fcolor;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len;
  logic             hit;

  logic             timer_clr_c;
  logic             timer_en_c;
  test_mode_t       mode_sel_c;
  logic             accept_c;
  logic             last_c;
  logic [LEN_W-1:0] idx_nxt_c;
  color_t           fcolor_nxt_c;
  disp_addr_t       addr_nxt_c;

  // Character for write k of a burst in the given mode.
  function automatic logic [7:0] cell_char(input test_mode_t mode, input logic [LEN_W-1:0] k);
    logic [MESSAGE_LEN*8-1:0] sh;
    sh = MESSAGE >> (8 * (MESSAGE_LEN - 1 - 32'(k)));
    case (mode)
      TEST_MODE_FILL:    return 8'h20;
      TEST_MODE_CHARSET: return 8'(k);
      default:           return sh[7:0];
    endcase
  endfunction

  video_frame_timer #(
    .FRAME_DELAY (FRAME_DELAY)
  ) u_frame_timer (
    .clk    (clk),
    .rst_ni (rst_ni),
    .clear  (timer_clr_c),
    .enable (timer_en_c),
    .hit    (hit)
  );

  // Frame gating, mode decode, handshake and next-write values.
  always_comb begin
    timer_en_c   = (state == TEST_WAIT) && enable_i && eof_i;
    timer_clr_c  = (state != TEST_WAIT) || !enable_i || hit;
    mode_sel_c   = ((mode_i == TEST_MODE_FILL) || (mode_i == TEST_MODE_CHARSET))
                   ? mode_i : TEST_MODE_MESSAGE;
    accept_c     = wr.wr_en_o && wr.wr_ready_i;
    last_c       = (idx == len - LEN_W'(1));
    idx_nxt_c    = idx + LEN_W'(1);
    fcolor_nxt_c = (mode_q == TEST_MODE_MESSAGE) ? color_t'(fcolor + color_t'(1)) : fcolor;
    addr_nxt_c   = (wr.wr_addr_o == LAST_ADDR) ? '0 : disp_addr_t'(wr.wr_addr_o + disp_addr_t'(1));
  end

  // Burst state machine with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state        <= TEST_WAIT;
      mode_q       <= TEST_MODE_MESSAGE;
      msg_addr     <= '0;
      bcolor       <= '0;
      fcolor       <= color_t'(1);
      idx          <= '0;
      len          <= '0;
      wr.wr_en_o   <= 1'b0;
      wr.wr_addr_o <= '0;
      wr.wr_data_o <= '0;
      busy_o       <= 1'b0;
      burst_done_o <= 1'b0;
    end else begin
      burst_done_o <= 1'b0;
      unique case (state)
        TEST_WAIT: begin
          if (enable_i && hit) begin
            state        <= TEST_WRITE;
            mode_q       <= mode_sel_c;
            idx          <= '0;
            wr.wr_en_o   <= 1'b1;
            busy_o       <= 1'b1;
            wr.wr_data_o <= make_cell(cell_char(mode_sel_c, LEN_W'(0)), fcolor, bcolor);
            if (mode_sel_c == TEST_MODE_FILL) begin
              len          <= LEN_W'(SCREEN_CELLS);
              wr.wr_addr_o <= '0;
            end else if (mode_sel_c == TEST_MODE_CHARSET) begin
              len          <= LEN_W'(CHARSET_LEN);
              wr.wr_addr_o <= '0;
            end else begin
              len          <= LEN_W'(MESSAGE_LEN);
              wr.wr_addr_o <= msg_addr;
            end
          end
        end
        TEST_WRITE: begin
          if (accept_c) begin
            wr.wr_addr_o <= addr_nxt_c;
            fcolor       <= fcolor_nxt_c;
            if (last_c) begin
              state        <= TEST_NEXT;
              wr.wr_en_o   <= 1'b0;
              busy_o       <= 1'b0;
              burst_done_o <= 1'b1;
            end else begin
              idx          <= idx_nxt_c;
              wr.wr_data_o <= make_cell(cell_char(mode_q, idx_nxt_c), fcolor_nxt_c, bcolor);
            end
          end
        end
        TEST_NEXT: begin
          bcolor <= color_t'(bcolor + color_t'(1));
          fcolor <= color_t'(bcolor + color_t'(2));
          if (mode_q == TEST_MODE_MESSAGE) begin
            msg_addr <= wr.wr_addr_o;
          end
          state <= TEST_WAIT;
        end
        default: state <= TEST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_video_test_gen.sv
// Directed bench for video_test_gen: 4x2 screen, 2-frame delay, message "ABC".
module tb_video_test_gen;
  import video_test_gen_pkg::*;

  logic       clk;
  logic       rst_ni;
  logic       enable_i;
  test_mode_t mode_i;
  logic       eof_i;
  logic       busy_o;
  logic       burst_done_o;

  video_test_gen_if wr_if ();

  video_test_gen #(
    .TEXT_COLS   (4),
    .TEXT_ROWS   (2),
    .FRAME_DELAY (2),
    .MESSAGE_LEN (3),
    .MESSAGE     (24'h414243)
  ) dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .mode_i       (mode_i),
    .eof_i        (eof_i),
    .wr           (wr_if),
    .busy_o       (busy_o),
    .burst_done_o (burst_done_o)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc      = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  int          q_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record accepted writes and burst completions, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_ni && wr_if.wr_en_o && wr_if.wr_ready_i) begin
      q_addr.push_back(32'(wr_if.wr_addr_o));
      q_data.push_back(32'(wr_if.wr_data_o));
      q_cyc.push_back(cyc);
    end
    if (burst_done_o) begin
      done_cnt++;
      check("done_en_busy_low", 32'({wr_if.wr_en_o, busy_o}), 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_eof();
    eof_i = 1'b1;
    step(1);
    eof_i = 1'b0;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic wait_done(input string tag);
    int start;
    start = done_cnt;
    for (int i = 0; i < 200 && done_cnt == start; i++) step(1);
    step(3);
    check({tag, "_done_once"}, 32'(done_cnt - start), 32'd1);
  endtask

  task automatic wait_wr_en(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_if.wr_en_o) break;
    end
    check(tag, 32'(wr_if.wr_en_o), 32'd1);
  endtask

  task automatic check_wr(input string tag, input int i, input logic [31:0] ea, input logic [31:0] ed);
    if (i < q_addr.size()) begin
      check({tag, "_addr"}, q_addr[i], ea);
      check({tag, "_data"}, q_data[i], ed);
    end else begin
      check({tag, "_missing"}, 32'(q_addr.size()), 32'(i + 1));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, 32'(wr_if.wr_en_o), 32'd0);
    check({tag, "_addr"}, 32'(wr_if.wr_addr_o), 32'd0);
    check({tag, "_data"}, 32'(wr_if.wr_data_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(burst_done_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; enable_i = 1'b1; mode_i = TEST_MODE_MESSAGE; eof_i = 1'b0;
    wr_if.wr_ready_i = 1'b1;
    step(3);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_ni = 1'b1;
    step(1);

    // Colour rule on the packaged helper.
    check("fore_eq_3", 32'(emit_fore(4'd3, 4'd3)), 32'd8);
    check("fore_eq_15", 32'(emit_fore(4'd15, 4'd15)), 32'd4);
    check("fore_ne", 32'(emit_fore(4'd3, 4'd4)), 32'd3);

    // Burst 1: MESSAGE at 0, latency and consecutive writes.
    clear_q();
    pulse_eof();
    pulse_eof();
    @(negedge clk);
    check("lat_edge_n", 32'(wr_if.wr_en_o), 32'd0);
    @(negedge clk);
    check("lat_edge_n1_en", 32'(wr_if.wr_en_o), 32'd1);
    check("lat_edge_n1_busy", 32'(busy_o), 32'd1);
    check("lat_edge_n1_addr", 32'(wr_if.wr_addr_o), 32'd0);
    wait_done("b1");
    check("b1_count", 32'(q_addr.size()), 32'd3);
    check_wr("b1_w0", 0, 32'd0, 32'h0141);
    check_wr("b1_w1", 1, 32'd1, 32'h0242);
    check_wr("b1_w2", 2, 32'd2, 32'h0343);
    if (q_cyc.size() >= 3) check("b1_consecutive", 32'(q_cyc[2] - q_cyc[0]), 32'd2);

    // Burst 2: continues at 3 with bcolor 1.
    clear_q();
    pulse_eof(); pulse_eof();
    wait_done("b2");
    check("b2_count", 32'(q_addr.size()), 32'd3);
    check_wr("b2_w0", 0, 32'd3, 32'h1241);
    check_wr("b2_w2", 2, 32'd5, 32'h1443);

    // Burst 3: straddles the last cell.
    clear_q();
    pulse_eof(); pulse_eof();
    wait_done("b3");
    check("b3_count", 32'(q_addr.size()), 32'd3);
    check_wr("b3_w0", 0, 32'd6, 32'h2341);
    check_wr("b3_w1", 1, 32'd7, 32'h2442);
    check_wr("b3_w2", 2, 32'd0, 32'h2543);

    // Burst 4: ready dropped for 4 cycles after the first write.
    clear_q();
    pulse_eof(); pulse_eof();
    wait_wr_en("bp_start");
    @(posedge clk); #1;
    wr_if.wr_ready_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_hold_addr", 32'(wr_if.wr_addr_o), 32'd2);
      check("bp_hold_data", 32'(wr_if.wr_data_o), 32'h3542);
    end
    @(posedge clk); #1;
    wr_if.wr_ready_i = 1'b1;
    wait_done("bp");
    check("bp_count", 32'(q_addr.size()), 32'd3);
    check_wr("bp_w0", 0, 32'd1, 32'h3441);
    check_wr("bp_w1", 1, 32'd2, 32'h3542);
    check_wr("bp_w2", 2, 32'd3, 32'h3643);

    // Reset during the second write abandons the burst.
    clear_q();
    pulse_eof(); pulse_eof();
    wait_wr_en("rst_start");
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst_mid");
    clear_q();
    pulse_eof(); pulse_eof();
    wait_done("rst_after");
    check("rst_after_count", 32'(q_addr.size()), 32'd3);
    check_wr("rst_after_w0", 0, 32'd0, 32'h0141);
    check_wr("rst_after_w2", 2, 32'd2, 32'h0343);

    // FILL after a clean reset; mode_i changes mid-burst.
    rst_ni = 1'b0;
    step(2);
    rst_ni = 1'b1;
    mode_i = TEST_MODE_FILL;
    clear_q();
    pulse_eof(); pulse_eof();
    step(3);
    mode_i = TEST_MODE_CHARSET;
    wait_done("fill");
    check("fill_count", 32'(q_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) check_wr("fill_w", i, 32'(i), 32'h0120);

    // CHARSET with an eof pulse during the burst.
    clear_q();
    pulse_eof(); pulse_eof();
    step(4);
    pulse_eof();
    wait_done("cs");
    check("cs_count", 32'(q_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) check_wr("cs_w", i, 32'(i), 32'h1200 | 32'(i));

    // Frame counting: disable clears the count, eof while disabled is ignored.
    mode_i = TEST_MODE_MESSAGE;
    clear_q();
    pulse_eof();
    enable_i = 1'b0;
    step(2);
    pulse_eof();
    step(1);
    enable_i = 1'b1;
    step(1);
    pulse_eof();
    step(6);
    check("fc_no_early_burst", 32'(q_addr.size()), 32'd0);
    check("fc_idle_wr_en", 32'(wr_if.wr_en_o), 32'd0);
    pulse_eof();
    wait_done("fc");
    check("fc_count", 32'(q_addr.size()), 32'd3);
    check_wr("fc_w0", 0, 32'd0, 32'h2341);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_test_gen.md
# video_test_gen

Parametrised text-mode test-pattern writer, successor to the fixed single-message display tester. It sits between the video timing generator, which supplies `eof_i`, and the display-memory write port. After a programmable number of frames it writes one burst of character cells. The burst is a scrolling message, a full-screen fill, or a charset dump, selected by `mode_i`. Every write uses a valid/ready handshake, so the block tolerates an arbitrated memory port.

## Interface
Parameters:
- `TEXT_COLS`, 80: text columns.
- `TEXT_ROWS`, 30: text rows. Screen size is `SCREEN_CELLS = TEXT_COLS*TEXT_ROWS`, and it must be ≤ 2^width(`disp_addr_t`).
- `FRAME_DELAY`, 300: frames to wait between bursts. Must be ≥ 1.
- `MESSAGE_LEN`, 20: message length in characters. Must be ≥ 1.
- `MESSAGE`, "Hello Upduino VGA!  ": `MESSAGE_LEN*8` bits. The first character is in the MSB byte.

Ports:
- `clk`, in, 1: the only clock.
- `rst_ni`, in, 1: reset; synchronous, active-low.
- `enable_i`, in, 1: when low, the block idles in WAIT with the frame counter held at 0.
- `mode_i`, in, 2: burst type. 0 = MESSAGE, 1 = FILL, 2 = CHARSET, 3 = reserved (treated as MESSAGE).
- `eof_i`, in, 1: one-cycle end-of-frame pulse.
- `wr_en_o`, out, 1: write valid.
- `wr_ready_i`, in, 1: memory accepts the write. A transfer occurs when `wr_en_o && wr_ready_i`.
- `wr_addr_o`, out, `disp_addr_t`: cell address.
- `wr_data_o`, out, `disp_data_t`: cell data as {back `color_t`, fore `color_t`, char[7:0]}.
- `busy_o`, out, 1: high while in state WRITE.
- `burst_done_o`, out, 1: one-cycle pulse when a burst ends.

## Operation
State machine, `test_st`:
- **WAIT**
  - Frame counter increments on `eof_i`.
  - When the counter reaches `FRAME_DELAY`, the block latches `mode_i`, clears the counter and goes to WRITE. It loads the burst length and start address:
    - MESSAGE: `MESSAGE_LEN` writes, starting at the running address `msg_addr`.
    - FILL: `SCREEN_CELLS` writes, starting at 0.
    - CHARSET: `min(256, SCREEN_CELLS)` writes, starting at 0.
- **WRITE**
  - `wr_en_o` stays high. Address and data are held stable until accepted.
  - On each accepted write, the address advances by 1. It wraps from `SCREEN_CELLS-1` to 0.
  - Character per mode:
    - MESSAGE: message byte k (k = 0 first).
    - FILL: 0x20.
    - CHARSET: the index 0..255.
  - After the last accepted write, go to NEXT.
- **NEXT**, one cycle:
  - Pulse `burst_done_o`.
  - `bcolor <= bcolor+1`, `fcolor <= old bcolor+2`.
  - In MESSAGE mode, `msg_addr` takes the wrapped post-burst address.
  - Return to WAIT.

Colour rules:
- Colours are 4-bit, and all colour arithmetic is mod 16.
- The emitted foreground is `fcolor+5` when `fcolor == bcolor`, otherwise `fcolor`.
- In MESSAGE mode, `fcolor` increments on every accepted write.
- In FILL and CHARSET modes, `fcolor` is constant for the burst.

Boundary conditions:
- `eof_i` in WRITE or NEXT is ignored and does not count.
- `mode_i` and `enable_i` changes during WRITE are ignored. The burst always completes.
- `enable_i` low in WAIT clears the counter.
- Address wrap inside a burst is legal, for example a message that straddles the last cell.
- `wr_ready_i` may toggle arbitrarily. With no acceptance, outputs stay unchanged.

Reset (`rst_ni` low at a clock edge):
- The block enters WAIT.
- Counter, `msg_addr` and `bcolor` go to 0; `fcolor` goes to 1.
- `wr_en_o`, `wr_addr_o`, `wr_data_o`, `busy_o` and `burst_done_o` all go to 0.
- Reset mid-burst abandons the burst. `wr_en_o` is low in the cycle after the reset edge.

## Timing
- All outputs are registered.
- The `eof_i` that completes the delay is sampled at edge N. `wr_en_o` and `busy_o` go high after edge N+1, and the first address/data are valid then.
- With `wr_ready_i` held high, writes are accepted one per cycle, so an L-write burst holds `wr_en_o` for exactly L cycles.
- `burst_done_o` is high for the single cycle after the last acceptance. `wr_en_o` and `busy_o` are low in that same cycle.
- Burst period is `FRAME_DELAY` frames, counted from the first frame edge after NEXT.

## Structure
- `video_package.svh` holds:
  - `disp_addr_t`, `disp_data_t` and `color_t`;
  - the `test_st` enum (WAIT, WRITE, NEXT);
  - the mode constants `TEST_MODE_MESSAGE`, `TEST_MODE_FILL` and `TEST_MODE_CHARSET`.
- One natural sub-module: `video_frame_timer`. It counts `eof_i` up to `FRAME_DELAY` and has clear and enable inputs and a `hit` output.
- Address wrap, colour logic and the handshake stay in the top module.

## Test plan
Bench parameters unless stated otherwise: `TEXT_COLS=4`, `TEXT_ROWS=2`, `FRAME_DELAY=2`, `MESSAGE_LEN=3`, message "ABC". Stated results are for the first burst after reset.
- **MESSAGE, ready high.** Stimulus: 2 `eof_i` pulses. Response:
  - writes to addresses 0, 1, 2 on consecutive cycles, data 0x0141, 0x0242, 0x0343;
  - `burst_done_o` pulses once;
  - on the next burst, first address is 3 and bcolor is 1.
- **Wrap.**
  - Stimulus: 3 MESSAGE bursts. Response: third-burst addresses are 6, 7, 0.
  - Stimulus: `bcolor` = `fcolor` = 3. Response: emitted foreground is 8.
- **Backpressure.** Stimulus: drop `wr_ready_i` for 4 cycles mid-burst. Response: address and data are held, no write is lost or duplicated, and the total burst is 3 accepted writes.
- **FILL / CHARSET.**
  - FILL: 8 writes, addresses 0..7, char 0x20, attr 0x01.
  - CHARSET: 8 writes, chars 0x00..0x07.
  - Changing `mode_i` mid-burst has no effect.
- **Frame counting.** Stimulus: `eof_i` during WRITE, and `enable_i` low in WAIT after 1 frame. Response: neither eof counts; after re-enable, 2 fresh frames are needed.
- **Reset.** Stimulus: `rst_ni` low during the 2nd write. Response:
  - `wr_en_o` = 0 the next cycle and all outputs are 0;
  - the next burst starts at address 0 with attr 0x01.
